// File: rtl/bus_xfer_seq_pkg.sv
// Shared types and helpers for the bus transfer sequencer.
package xfer_pkg;

  // Sequencer phases. One move runs DRIVE -> LATCH -> DONE and then returns to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } xfer_state_t;

  // The register file needs at least two entries.
  localparam int XFER_MIN_NREG = 2;

  // Width of a register index. It never returns 0, so a 1-entry corner case still
  // gets a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_xfer_seq_if.sv
// Command handshake and gated-bus signals between the sequencer and its environment.
interface bus_xfer_seq_if
  import xfer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREG  = 4
);

  // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready.
  // The requester holds cmd_valid/cmd_src/cmd_dst stable until that edge.
  // cmd_ready never depends on cmd_valid in the same cycle.
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [idx_w(NREG)-1:0]   cmd_src;
  logic [idx_w(NREG)-1:0]   cmd_dst;

  // Gated bus: bus_en/bus_data go to the gate, and bus_in is the gate's output.
  logic                     bus_en;
  logic [WIDTH-1:0]         bus_data;
  logic [WIDTH-1:0]         bus_in;

  // Sequencer side.
  modport master (
    input  cmd_valid, cmd_src, cmd_dst, bus_in,
    output cmd_ready, bus_en, bus_data
  );

  // Requester / gate side.
  modport slave (
    output cmd_valid, cmd_src, cmd_dst, bus_in,
    input  cmd_ready, bus_en, bus_data
  );

endinterface

// File: rtl/bus_xfer_seq_regfile.sv
// NREG x WIDTH register file: one write port and two asynchronous read ports.
module xfer_regfile
  import xfer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREG  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_we,
  input  logic [idx_w(NREG)-1:0] i_waddr,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic [idx_w(NREG)-1:0] i_raddr_a,
  output logic [WIDTH-1:0]       o_rdata_a,
  input  logic [idx_w(NREG)-1:0] i_raddr_b,
  output logic [WIDTH-1:0]       o_rdata_b
);

  logic [WIDTH-1:0] r_mem [NREG];

  // Storage: cleared on reset, single write per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // NREG is a power of two, so every index value addresses a real entry.
  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/bus_xfer_seq.sv
// Register-to-register move sequencer driving an edge-sensitive downstream bus gate.
module bus_xfer_seq
  import xfer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREG  = 4,
  parameter int HOLD  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bus_xfer_seq_if.master         bif,
  input  logic                   load_en,
  input  logic [idx_w(NREG)-1:0] load_sel,
  input  logic [WIDTH-1:0]       load_data,
  output logic                   busy,
  output logic                   done,
  input  logic [idx_w(NREG)-1:0] rd_sel,
  output logic [WIDTH-1:0]       rd_data,
  output xfer_state_t            o_dbg_state
);

  localparam int IW = idx_w(NREG);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  if (HOLD < 1) begin : g_bad_hold
    $fatal(1, "bus_xfer_seq: HOLD must be >= 1");
  end
  if ((NREG < XFER_MIN_NREG) || ((NREG & (NREG - 1)) != 0)) begin : g_bad_nreg
    $fatal(1, "bus_xfer_seq: NREG must be a power of two and >= 2");
  end

  xfer_state_t      r_state;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_src;
  logic [IW-1:0]    r_dst;
  logic             r_bus_en;
  logic             r_done;

  logic             w_load;
  logic             w_cap;
  logic             w_we;
  logic [IW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_src_data;

  // Loads are accepted only while idle. Capture happens only on the edge that leaves LATCH.
  // The two writes can never happen in the same cycle.
  assign w_load  = (r_state == IDLE) && load_en;
  assign w_cap   = (r_state == LATCH);
  assign w_we    = w_load || w_cap;
  assign w_waddr = w_cap ? r_dst : load_sel;
  assign w_wdata = w_cap ? bif.bus_in : load_data;

  xfer_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (r_src),
    .o_rdata_a (w_src_data),
    .i_raddr_b (rd_sel),
    .o_rdata_b (rd_data)
  );

  // Transfer FSM. bus_en is its own flop, so the gate never sees a decode glitch.
  // The asynchronous reset drops it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_bus_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bif.cmd_valid) begin
            r_src    <= bif.cmd_src;
            r_dst    <= bif.cmd_dst;
            r_cnt    <= '0;
            r_bus_en <= 1'b1;
            r_state  <= DRIVE;
          end
        end
        DRIVE: begin
          if (r_cnt == CW'(HOLD - 1)) begin
            r_state <= LATCH;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        LATCH: begin
          r_bus_en <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Source registers are stable through DRIVE and LATCH, so bus_data is driven
  // straight from the register file. A same-edge load is therefore already visible.
  assign bif.bus_data  = r_bus_en ? w_src_data : '0;
  assign bif.bus_en    = r_bus_en;
  assign bif.cmd_ready = (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Randomised and directed bench for bus_xfer_seq with a cycle-count transaction model.
`timescale 1ns/1ps
module tb_bus_xfer_seq;
  import xfer_pkg::*;

  localparam int WIDTH = 4;
  localparam int NREG  = 4;
  localparam int HOLD  = 2;
  localparam int IW    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  bus_xfer_seq_if #(.WIDTH(WIDTH), .NREG(NREG)) bif ();

  logic             load_en;
  logic [IW-1:0]    load_sel;
  logic [WIDTH-1:0] load_data;
  logic             busy;
  logic             done;
  logic [IW-1:0]    rd_sel;
  logic [WIDTH-1:0] rd_data;
  xfer_state_t      dbg_state;
  logic [WIDTH-1:0] gate_mask;

  // Gate model: the bus returns bus_data ANDed with a mask chosen by the bench.
  assign bif.bus_in = bif.bus_data & gate_mask;

  bus_xfer_seq #(.WIDTH(WIDTH), .NREG(NREG), .HOLD(HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bif         (bif),
    .load_en     (load_en),
    .load_sel    (load_sel),
    .load_data   (load_data),
    .busy        (busy),
    .done        (done),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transfer is described by its acceptance edge number. All outputs follow from
  // the distance d = cyc - m_acc: bus_en for d in 0..HOLD, done at HOLD+1,
  // idle again from HOLD+2.
  logic [WIDTH-1:0] m_reg [NREG];
  bit               m_active;
  int               m_acc;
  int               m_src, m_dst;
  int               cyc;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_active = 1'b0;
    m_acc    = 0;
    m_src    = 0;
    m_dst    = 0;
  endtask

  task automatic model_edge();
    int d;
    cyc++;
    if (!rst_n) return;
    if (m_active) begin
      d = cyc - m_acc;
      if (d == HOLD + 1) m_reg[m_dst] = m_reg[m_src] & gate_mask;
      if (d == HOLD + 2) m_active = 1'b0;
    end else begin
      if (load_en) m_reg[load_sel] = load_data;
      if (bif.cmd_valid) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_src    = int'(bif.cmd_src);
        m_dst    = int'(bif.cmd_dst);
      end
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      int  d;
      bit  e_en;
      d    = cyc - m_acc;
      e_en = m_active && (d <= HOLD);
      chk("cmd_ready", bif.cmd_ready, !m_active);
      chk("busy",      busy,          m_active);
      chk("bus_en",    bif.bus_en,    e_en);
      chk("bus_data",  bif.bus_data,  e_en ? m_reg[m_src] : '0);
      chk("done",      done,          m_active && (d == HOLD + 1));
      chk("rd_data",   rd_data,       m_reg[rd_sel]);
    end
  end

  // ---------------- driver tasks ----------------
  // Set the inputs for one cycle, pass the rising edge, update the model, and settle.
  task automatic cycle_in(input bit v, input int src, input int dst,
                          input bit le, input int ls, input int ld);
    bif.cmd_valid = v;
    bif.cmd_src   = IW'(src);
    bif.cmd_dst   = IW'(dst);
    load_en       = le;
    load_sel      = IW'(ls);
    load_data     = WIDTH'(ld);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic peek(input int idx, input logic [WIDTH-1:0] exp, input string name);
    rd_sel = IW'(idx);
    #1;
    chk(name, rd_data, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int en_cnt, done_at, rdy_at, done_cnt;
    rst_n = 1'b0;
    bif.cmd_valid = 1'b0;
    bif.cmd_src = '0;
    bif.cmd_dst = '0;
    load_en = 1'b0;
    load_sel = '0;
    load_data = '0;
    rd_sel = '0;
    gate_mask = '1;
    cyc = 0;
    model_reset();
    @(posedge clk); model_edge(); #1;
    @(posedge clk); model_edge(); #1;
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Reset state.
    chk("rst_ready", bif.cmd_ready, 1'b1);
    chk("rst_bus_en", bif.bus_en, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    for (int i = 0; i < NREG; i++) peek(i, 4'h0, "rst_reg");

    // Load reg1=A, then move 1->3 through a transparent gate.
    cycle_in(0, 0, 0, 1, 1, 4'hA);
    cycle_in(1, 1, 3, 0, 0, 0);
    en_cnt = 0; done_at = -1; rdy_at = -1;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) cycle_in(0, 0, 0, 0, 0, 0);
      if (k == 0) chk("t1_bus_data", bif.bus_data, 4'hA);
      if (bif.bus_en) en_cnt++;
      if (done && done_at < 0) done_at = k;
      if (bif.cmd_ready && rdy_at < 0) rdy_at = k;
    end
    chk("t1_en_cycles", en_cnt, 3);
    chk("t1_done_at", done_at, 3);
    chk("t1_ready_at", rdy_at, 4);
    peek(3, 4'hA, "t1_reg3");

    // Masked return: reg2=5, move 2->2 with the gate returning 0.
    cycle_in(0, 0, 0, 1, 2, 4'h5);
    gate_mask = '0;
    cycle_in(1, 2, 2, 0, 0, 0);
    done_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      cycle_in(0, 0, 0, 0, 0, 0);
      if (done) done_cnt++;
    end
    gate_mask = '1;
    chk("t2_done_cnt", done_cnt, 1);
    peek(2, 4'h0, "t2_reg2");

    // cmd_valid held through busy with changing fields.
    cycle_in(0, 0, 0, 1, 0, 4'h1);
    cycle_in(0, 0, 0, 1, 1, 4'h2);
    cycle_in(0, 0, 0, 1, 2, 4'h3);
    cycle_in(0, 0, 0, 1, 3, 4'h4);
    cycle_in(1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 3; k++) cycle_in(1, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0);
    cycle_in(1, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0);
    chk("t3_ready_e4", bif.cmd_ready, 1'b1);
    cycle_in(1, 3, 2, 0, 0, 0);
    chk("t3_second_en", bif.bus_en, 1'b1);
    chk("t3_second_data", bif.bus_data, 4'h4);
    idle_cycles(5);
    peek(1, 4'h1, "t3_reg1");
    peek(2, 4'h4, "t3_reg2");

    // Same-cycle load of reg0 with move 0->1. A load during DRIVE is dropped.
    cycle_in(1, 0, 1, 1, 0, 4'h7);
    cycle_in(0, 0, 0, 1, 2, 4'h9);
    idle_cycles(4);
    peek(1, 4'h7, "t4_reg1");
    peek(2, 4'h4, "t4_reg2_kept");

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: gate_mask = '1;
        1: gate_mask = '0;
        default: gate_mask = WIDTH'($urandom_range(0, 15));
      endcase
      rd_sel = IW'($urandom_range(0, 3));
      cycle_in($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
               ($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 15));
    end
    gate_mask = '1;
    idle_cycles(6);

    // Reset during DRIVE: bus_en drops at once, with no write and no done.
    cycle_in(0, 0, 0, 1, 3, 4'hC);
    cycle_in(1, 3, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_bus_en_async", bif.bus_en, 1'b0);
    chk("t5_done", done, 1'b0);
    cycle_in(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    peek(0, 4'h0, "t5_dst_unwritten");
    chk("t5_ready", bif.cmd_ready, 1'b1);
    cycle_in(0, 0, 0, 1, 0, 4'h3);
    cycle_in(1, 0, 1, 0, 0, 0);
    done_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      cycle_in(0, 0, 0, 0, 0, 0);
      if (done) done_cnt++;
    end
    chk("t5_after_done", done_cnt, 1);
    peek(1, 4'h3, "t5_after_reg1");

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
